// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of the synchronous FIFO.
// Owns the write pointer, occupancy count and full/afull flags, and drives
// the write port of the shared storage array. Accepted pops from the read
// side are folded into the count so both ends agree on occupancy.
// Optional error status (ovf/udf/ovf_cnt) is built only when the macro
// FIFO_WR_ERR_CHK_EN is defined; otherwise those outputs are tied to 0.
module fifo_wr_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int unsigned CNT_WIDTH  = ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) ?
                                      ADDR_WIDTH + 1 : ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_pop,
  input  logic [CNT_WIDTH-1:0]  afull_th,
  output logic                  full,
  output logic                  afull,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  ovf_clr,
  output logic                  ovf,
  output logic                  udf,
  output logic [7:0]            ovf_cnt
);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;

  // Accepted push/pop; rst_n gates push so mem_we drops during reset.
  always_comb begin
    push = rst_n & wr_en & ~full_q;
    pop  = rd_pop & (cnt_q != '0);
  end

  // Next pointer, occupancy and flags, all derived from the next count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    end
    full_d  = (cnt_d == CNT_FULL);
    afull_d = (cnt_d >= afull_th);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

  assign full      = full_q;
  assign afull     = afull_q;
  assign cnt       = cnt_q;
  assign mem_we    = push;
  assign mem_waddr = wr_ptr_q;
  assign mem_wdata = wr_data;

`ifdef FIFO_WR_ERR_CHK_EN
  logic       drop;
  logic       empty_pop;
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Sticky error status; a set event in the clear cycle keeps the flag set.
  always_comb begin
    drop      = wr_en & full_q;
    empty_pop = rd_pop & (cnt_q == '0);
    ovf_d     = drop | (ovf_q & ~ovf_clr);
    udf_d     = empty_pop | (udf_q & ~ovf_clr);
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  // Error status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      ovf_cnt_q <= 8'd0;
    end else begin
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf     = ovf_q;
  assign udf     = udf_q;
  assign ovf_cnt = ovf_cnt_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf     = 1'b0;
  assign udf     = 1'b0;
  assign ovf_cnt = 8'd0;
`endif

endmodule
